// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: state codes, opcodes,
// datapath select encodings and the control word passed from decode to top.
package mips_ctrl_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // Pure state decode; the *_upd and done_on_ready flags are qualified by
   // mem_ready/zero in the top level.
   typedef struct packed {
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       fetch_upd;
      logic       branch_upd;
      logic       jump_upd;
      logic       done_always;
      logic       done_on_ready;
   } ctrl_word_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state -> control word decode; unused state codes yield an
// all-zero word.
module ctrl_out_decode
   import mips_ctrl_pkg::*;
(
   input  logic [STATE_W-1:0] state,
   output ctrl_word_t         ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.fetch_upd = 1'b1;
         end
         S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
         S_MEMADR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.i_or_d   = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         S_MEMWB: begin
            ctrl.mem_to_reg  = 1'b1;
            ctrl.reg_write   = 1'b1;
            ctrl.done_always = 1'b1;
         end
         S_MEMWR: begin
            ctrl.i_or_d        = 1'b1;
            ctrl.mem_write     = 1'b1;
            ctrl.done_on_ready = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_dst     = 1'b1;
            ctrl.reg_write   = 1'b1;
            ctrl.done_always = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_op      = ALU_SUB;
            ctrl.pc_src      = PC_ALUOUT;
            ctrl.branch_upd  = 1'b1;
            ctrl.done_always = 1'b1;
         end
         S_ADDIWB: begin
            ctrl.reg_write   = 1'b1;
            ctrl.done_always = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_src      = PC_JUMP;
            ctrl.jump_upd    = 1'b1;
            ctrl.done_always = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS main controller: state register, opcode-driven next state,
// and mem_ready/zero qualification of the decoded control word.
module multicycle_ctrl_fsm
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t     state_q, state_d;
   ctrl_word_t ctrl;
   logic       op_legal;
   logic       take_branch;
   logic       active;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW)  || (opcode == OP_SW) ||
                     (opcode == OP_BEQ)   || (opcode == OP_BNE) || (opcode == OP_ADDI) ||
                     (opcode == OP_J);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:   state_d = S_MEMADR;
               OP_RTYPE:       state_d = S_EXECUTE;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_ADDI:        state_d = S_ADDIEX;
               OP_J:           state_d = S_JUMP;
               default:        state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
         S_MEMWR:   if (mem_ready) state_d = S_FETCH;
         S_EXECUTE: state_d = S_ALUWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         default:   state_d = S_FETCH;
      endcase
   end

   ctrl_out_decode u_decode (
      .state (state_q),
      .ctrl  (ctrl)
   );

   // Only beq/bne reach BRANCH, so bne inverts the sense of zero.
   assign take_branch = zero ^ (opcode == OP_BNE);
   assign active      = ~reset;

   assign i_or_d     = active & ctrl.i_or_d;
   assign mem_read   = active & ctrl.mem_read;
   assign mem_write  = active & ctrl.mem_write;
   assign ir_write   = active & ctrl.fetch_upd & mem_ready;
   assign reg_dst    = active & ctrl.reg_dst;
   assign mem_to_reg = active & ctrl.mem_to_reg;
   assign reg_write  = active & ctrl.reg_write;
   assign alu_src_a  = active & ctrl.alu_src_a;
   assign alu_src_b  = active ? ctrl.alu_src_b : 2'b00;
   assign alu_op     = active ? ctrl.alu_op    : 2'b00;
   assign pc_src     = active ? ctrl.pc_src    : 2'b00;
   assign pc_en      = active & ((ctrl.fetch_upd & mem_ready) |
                                 (ctrl.branch_upd & take_branch) |
                                 ctrl.jump_upd);
   assign instr_done = active & (ctrl.done_always | (ctrl.done_on_ready & mem_ready));
   assign illegal_op = active & (state_q == S_DECODE) & ~op_legal;
   assign state      = active ? state_q : S_FETCH;

endmodule
